// File: rtl/fetch_stage_if.sv
// Bundles the instruction-memory request/response channel, the redirect
// strobe and the decode-side handshake of the fetch stage.
//
// Handshake semantics: imem side is req/gnt (a request is accepted on a cycle
// with imem_req_o & imem_gnt_i; req may drop without a grant), followed in
// order by exactly one imem_rvalid_i pulse no earlier than the cycle after
// the grant. Decode side is valid/ready: a transfer happens on a cycle with
// dec_valid_o & dec_ready_i, and while valid is high and ready is low the
// presented pc/insn are held stable.
interface fetch_stage_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              imem_req_o;
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DWIDTH-1:0] imem_rdata_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              dec_valid_o;
  logic [AWIDTH-1:0] dec_pc_o;
  logic [DWIDTH-1:0] dec_insn_o;
  logic              dec_ready_i;

  // Fetch stage side
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output dec_valid_o,
    output dec_pc_o,
    output dec_insn_o,
    input  dec_ready_i
  );

  // Environment side: instruction memory, branch unit and decode
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  dec_valid_o,
    input  dec_pc_o,
    input  dec_insn_o,
    output dec_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt,
// pairs each in-order response with its PC in a 2-entry FIFO and hands them
// to decode over valid/ready. A redirect reloads the PC, flushes buffered
// work and turns every still-owed response into one that must be dropped.
module fetch_stage #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus,
  output logic          dbg_state,
  output logic [1:0]    dbg_inflight,
  output logic [1:0]    dbg_drop,
  output logic [1:0]    dbg_fifo_count
);

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] redirect_target;

  // Addresses of granted, not yet answered fetches (occupancy == inflight_q)
  logic [AWIDTH-1:0] aq_mem [2];
  logic              aq_wr_q, aq_rd_q;

  // Returned instructions waiting for decode
  logic [AWIDTH-1:0] fifo_pc   [2];
  logic [DWIDTH-1:0] fifo_insn [2];
  logic              fifo_wr_q, fifo_rd_q;

  logic [1:0] inflight_q;
  logic [1:0] drop_q;
  logic [1:0] fifo_count_q;

  logic [2:0] credit_used;
  logic [2:0] redir_pend;
  logic [2:0] redir_drop;
  logic       issue;
  logic       gnt_fire;
  logic       rsp_drop;
  logic       rsp_take;
  logic       dec_valid;
  logic       pop;

  // Credit, response classification and redirect bookkeeping
  always_comb begin
    credit_used     = {1'b0, inflight_q} + {1'b0, fifo_count_q};
    redir_pend      = {1'b0, drop_q} + {1'b0, inflight_q};
    redirect_target = bus.redirect_pc_i & ~AWIDTH'(3);
    gnt_fire        = issue && bus.imem_gnt_i;
    rsp_drop        = bus.imem_rvalid_i && (drop_q != 2'd0);
    // An rvalid nobody is owed (inflight 0, drop 0) is simply ignored
    rsp_take        = bus.imem_rvalid_i && (drop_q == 2'd0) && (inflight_q != 2'd0);
    dec_valid       = reset_n && (fifo_count_q != 2'd0);
    pop             = dec_valid && bus.dec_ready_i;
    // A response arriving in the redirect cycle is itself one of the stale ones
    if (bus.imem_rvalid_i && (redir_pend != 3'd0)) begin
      redir_drop = redir_pend - 3'd1;
    end else begin
      redir_drop = redir_pend;
    end
  end

  // FSM next state and issue decision: one quiet boot cycle, then run
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_RUN;
        issue   = reset_n && !bus.redirect_i && (credit_used < 3'd2);
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // FSM state register; only reset brings it back to boot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // PC: redirect wins over the post-grant increment (which wraps naturally)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= BASEADDR;
    end else if (bus.redirect_i) begin
      pc_q <= redirect_target;
    end else if (gnt_fire) begin
      pc_q <= pc_q + AWIDTH'(4);
    end
  end

  // Address queue pointers: push on grant, pop on an accepted response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      aq_wr_q <= 1'b0;
      aq_rd_q <= 1'b0;
    end else if (bus.redirect_i) begin
      aq_wr_q <= 1'b0;
      aq_rd_q <= 1'b0;
    end else begin
      if (gnt_fire) begin
        aq_wr_q <= ~aq_wr_q;
      end
      if (rsp_take) begin
        aq_rd_q <= ~aq_rd_q;
      end
    end
  end

  // Address queue storage (no reset needed: read only when occupied)
  always_ff @(posedge clk) begin
    if (gnt_fire) begin
      aq_mem[aq_wr_q] <= pc_q;
    end
  end

  // FIFO pointers: a redirect flushes, overriding any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
    end else if (bus.redirect_i) begin
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
    end else begin
      if (rsp_take) begin
        fifo_wr_q <= ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
    end
  end

  // FIFO storage: pair the oldest outstanding address with its instruction
  always_ff @(posedge clk) begin
    if (rsp_take && !bus.redirect_i) begin
      fifo_pc[fifo_wr_q]   <= aq_mem[aq_rd_q];
      fifo_insn[fifo_wr_q] <= bus.imem_rdata_i;
    end
  end

  // Occupancy counters for outstanding, to-be-dropped and buffered fetches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight_q   <= 2'd0;
      drop_q       <= 2'd0;
      fifo_count_q <= 2'd0;
    end else if (bus.redirect_i) begin
      inflight_q   <= 2'd0;
      drop_q       <= redir_drop[1:0];
      fifo_count_q <= 2'd0;
    end else begin
      case ({gnt_fire, rsp_take})
        2'b10:   inflight_q <= inflight_q + 2'd1;
        2'b01:   inflight_q <= inflight_q - 2'd1;
        default: inflight_q <= inflight_q;
      endcase
      if (rsp_drop) begin
        drop_q <= drop_q - 2'd1;
      end
      case ({rsp_take, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Outputs: request straight from state, decode view straight from FIFO head
  always_comb begin
    bus.imem_req_o  = issue;
    bus.imem_addr_o = pc_q;
    bus.dec_valid_o = dec_valid;
    bus.dec_pc_o    = dec_valid ? fifo_pc[fifo_rd_q]   : '0;
    bus.dec_insn_o  = dec_valid ? fifo_insn[fifo_rd_q] : '0;
    dbg_state       = (state_q == S_RUN);
    dbg_inflight    = inflight_q;
    dbg_drop        = drop_q;
    dbg_fifo_count  = fifo_count_q;
  end

  // Bookkeeping invariants: never more than two fetches owed, FIFO never overflows
  a_owed_le_2: assert property (@(posedge clk) disable iff (!reset_n)
    (({1'b0, drop_q} + {1'b0, inflight_q}) <= 3'd2));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp_take && (fifo_count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order memory responder with configurable
// latency, a PC/credit model and a scoreboard of expected {pc, insn} pairs.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic clk;
  logic reset_n;
  logic       dbg_state;
  logic [1:0] dbg_inflight;
  logic [1:0] dbg_drop;
  logic [1:0] dbg_fifo_count;

  fetch_stage_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  fetch_stage #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_inflight   (dbg_inflight),
    .dbg_drop       (dbg_drop),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mem_t;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        chk;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;

  logic        drv_reset_n = 1'b0;
  logic        drv_ready = 1'b1;
  logic        drv_gnt = 1'b1;
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = 32'h0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_insn;

  logic [31:0] m_pc = BASE;
  bit          m_boot = 1'b1;
  bit          m_prev_rst = 1'b1;
  int          m_fifo = 0;
  logic [63:0] exp_q [$];
  mem_t        mem_q [$];

  vec_t vecs [21];

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle with model + scoreboard ----------------
  task automatic cycle();
    logic req_exp;
    logic rsp;
    bit   rsp_live;
    logic [63:0] head;
    @(negedge clk);
    reset_n           = drv_reset_n;
    bus.redirect_i    = drv_redirect;
    bus.redirect_pc_i = drv_redirect_pc;
    bus.dec_ready_i   = drv_ready;
    bus.imem_gnt_i    = drv_gnt;
    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    bus.imem_rvalid_i = rsp;
    bus.imem_rdata_i  = rsp ? insn_of(mem_q[0].addr) : $urandom;
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = bus.dec_valid_o;
    s_pc    = bus.dec_pc_o;
    s_insn  = bus.dec_insn_o;

    if (!drv_reset_n) begin
      if (m_prev_rst) begin
        check("rst_req", s_req, 0);
        check("rst_valid", s_valid, 0);
        check("rst_pc", s_pc, 0);
        check("rst_insn", s_insn, 0);
      end
      m_pc = BASE;
      m_boot = 1'b1;
      m_fifo = 0;
      exp_q.delete();
      mem_q.delete();
      m_prev_rst = 1'b1;
    end else begin
      m_prev_rst = 1'b0;
      req_exp = !m_boot && !drv_redirect && (exp_q.size() < 2);
      check("state", dbg_state, !m_boot);
      check("req", s_req, req_exp);
      if (req_exp) check("addr", s_addr, m_pc);
      check("dec_valid", s_valid, m_fifo != 0);
      if (m_fifo != 0) begin
        head = exp_q[0];
        check("dec_pc", s_pc, head[63:32]);
        check("dec_insn", s_insn, head[31:0]);
      end
      rsp_live = 1'b0;
      if (rsp) begin
        rsp_live = mem_q[0].live;
        void'(mem_q.pop_front());
      end
      if (drv_redirect) begin
        m_pc = {drv_redirect_pc[31:2], 2'b00};
        exp_q.delete();
        m_fifo = 0;
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
      end else begin
        if ((m_fifo != 0) && drv_ready) begin
          void'(exp_q.pop_front());
          m_fifo--;
        end
        if (rsp_live) m_fifo++;
        if (req_exp && drv_gnt) begin
          exp_q.push_back({m_pc, insn_of(m_pc)});
          mem_q.push_back('{addr: m_pc, due: cyc + lat, live: 1'b1});
          m_pc = m_pc + 32'd4;
        end
      end
      m_boot = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    drv_reset_n = 1'b0;
    drv_redirect = 1'b0;
    repeat (n) cycle();
    drv_reset_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic rst_n, input logic ready, input logic chk,
                         input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc);
    vecs[i] = '{rst_n, ready, chk, req, addr, v, pc};
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    logic [31:0] tgt;
    reset_n = 1'b0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.dec_ready_i = 1'b0;

    // T1: reset then free-running fetch, grant every cycle, latency 1
    set_vec(0,  0, 1, 1, 0, 32'h0,        0, 32'h0);
    set_vec(1,  0, 1, 1, 0, 32'h0,        0, 32'h0);
    set_vec(2,  0, 1, 1, 0, 32'h0,        0, 32'h0);
    set_vec(3,  1, 1, 1, 0, 32'h0,        0, 32'h0);
    set_vec(4,  1, 1, 1, 1, BASE,         0, 32'h0);
    set_vec(5,  1, 1, 1, 1, BASE + 32'h4, 0, 32'h0);
    set_vec(6,  1, 1, 1, 0, 32'h0,        1, BASE);
    set_vec(7,  1, 1, 1, 1, BASE + 32'h8, 1, BASE + 32'h4);
    set_vec(8,  1, 1, 1, 1, BASE + 32'hC, 0, 32'h0);
    set_vec(9,  1, 1, 1, 0, 32'h0,        1, BASE + 32'h8);
    // T2: decode back-pressure, one single-cycle ready
    set_vec(10, 0, 0, 0, 0, 32'h0,        0, 32'h0);
    set_vec(11, 0, 0, 1, 0, 32'h0,        0, 32'h0);
    set_vec(12, 1, 0, 1, 0, 32'h0,        0, 32'h0);
    set_vec(13, 1, 0, 1, 1, BASE,         0, 32'h0);
    set_vec(14, 1, 0, 1, 1, BASE + 32'h4, 0, 32'h0);
    set_vec(15, 1, 0, 1, 0, 32'h0,        1, BASE);
    set_vec(16, 1, 0, 1, 0, 32'h0,        1, BASE);
    set_vec(17, 1, 1, 1, 0, 32'h0,        1, BASE);
    set_vec(18, 1, 0, 1, 1, BASE + 32'h8, 1, BASE + 32'h4);
    set_vec(19, 1, 0, 1, 0, 32'h0,        1, BASE + 32'h4);
    set_vec(20, 1, 0, 1, 0, 32'h0,        1, BASE + 32'h4);

    lat = 1;
    drv_gnt = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drv_reset_n = vecs[i].rst_n;
      drv_ready   = vecs[i].ready;
      cycle();
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_req", i), s_req, vecs[i].exp_req);
        if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
        if (vecs[i].exp_valid) begin
          check($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
          check($sformatf("vec%0d_insn", i), s_insn, insn_of(vecs[i].exp_pc));
        end
      end
    end

    // T3: redirect squashes two slow in-flight fetches
    lat = 3; drv_ready = 1'b1; drv_gnt = 1'b1;
    do_reset(2);
    cycle();
    cycle();
    check("t3_first_req", {s_req, s_addr}, {1'b1, BASE});
    cycle();
    drv_redirect = 1'b1; drv_redirect_pc = BASE + 32'h200;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    check("t3_drop", dbg_drop, 2);
    check("t3_target_req", {s_req, s_addr}, {1'b1, BASE + 32'h200});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (s_valid) found = 1'b1;
    end
    check("t3_found", found, 1);
    if (found) begin
      check("t3_pc", s_pc, BASE + 32'h200);
      check("t3_insn", s_insn, insn_of(BASE + 32'h200));
    end

    // T4: redirect coinciding with a response and a decode handshake
    lat = 1; drv_ready = 1'b0;
    do_reset(2);
    cycle();
    cycle();
    cycle();
    drv_ready = 1'b1; drv_redirect = 1'b1; drv_redirect_pc = BASE + 32'h200;
    cycle();
    check("t4_pre_fifo", dbg_fifo_count, 1);
    check("t4_pre_inflight", dbg_inflight, 1);
    drv_redirect = 1'b0;
    cycle();
    check("t4_valid", s_valid, 0);
    check("t4_drop", dbg_drop, 0);
    check("t4_fifo", dbg_fifo_count, 0);
    check("t4_req", {s_req, s_addr}, {1'b1, BASE + 32'h200});

    // T5: misaligned target and address wrap
    drv_redirect = 1'b1; drv_redirect_pc = 32'h0100_0102;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    check("t5_align", {s_req, s_addr}, {1'b1, 32'h0100_0100});
    drv_redirect = 1'b1; drv_redirect_pc = 32'hFFFF_FFFC;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    check("t5_top", {s_req, s_addr}, {1'b1, 32'hFFFF_FFFC});
    cycle();
    check("t5_wrap", {s_req, s_addr}, {1'b1, 32'h0000_0000});

    // T6: reset while work is buffered and outstanding
    lat = 1; drv_ready = 1'b0;
    do_reset(2);
    cycle();
    cycle();
    cycle();
    drv_reset_n = 1'b0;
    cycle();
    check("t6_pre_fifo", dbg_fifo_count, 1);
    check("t6_pre_inflight", dbg_inflight, 1);
    drv_reset_n = 1'b1;
    cycle();
    check("t6_valid", s_valid, 0);
    check("t6_boot_req", s_req, 0);
    check("t6_boot_state", dbg_state, 0);
    cycle();
    check("t6_req", {s_req, s_addr}, {1'b1, BASE});

    // T7: redirect during the boot cycle
    do_reset(1);
    drv_redirect = 1'b1; drv_redirect_pc = BASE + 32'h300;
    cycle();
    check("t7_boot_req", s_req, 0);
    drv_redirect = 1'b0;
    cycle();
    check("t7_req", {s_req, s_addr}, {1'b1, BASE + 32'h300});

    // Random traffic: grants, back-pressure, latencies, redirects, resets
    for (int i = 0; i < 600; i++) begin
      drv_gnt   = ($urandom_range(0, 3) != 0);
      drv_ready = ($urandom_range(0, 2) != 0);
      lat       = $urandom_range(1, 3);
      drv_redirect = ($urandom_range(0, 19) == 0);
      tgt = BASE + 32'($urandom_range(0, 1023));
      drv_redirect_pc = tgt;
      drv_reset_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    drv_redirect = 1'b0;
    drv_reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
